// File: rtl/cp0_exc_unit.sv
// CP0 register bank (STATUS/CAUSE/EPC) and MEM-stage exception sequencer for the 5-stage MIPS32 pipe.
// Optional COUNT/COMPARE timer on IP7 is built when CP0_TIMER_EN is defined.
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemValid,
    input  logic [31:0] MemPC,
    input  logic        ExcSyscall,
    input  logic        ExcEret,
    input  logic        ExcDelay,
    input  logic        IntIn,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        CP0We,
    input  logic [4:0]  CP0WAddr,
    input  logic [31:0] CP0WData,
    input  logic [4:0]  CP0RAddr,
    output logic [31:0] CP0RData,
    output logic        ExcRedirect,
    output logic [31:0] ExcPC,
    output logic        PCStall,
    output logic        IFIDStall,
    output logic        IDEXStall,
    output logic        PCFlush,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        EXMEFlush,
    output logic        MEWBFlush
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] CODE_INT     = 5'b00000;
    localparam logic [4:0] CODE_SYS     = 5'b01000;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t      state;
    logic        st_im4, st_exl, st_ie;
    logic        st_im7, ip7;
    logic        cause_bd;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        int_meta, ip4;

    logic intp, can_take, take_int, take_sys, take_eret, taken, wr_en;

    // IP4 tracks the external level, it is never latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_meta <= 1'b0;
            ip4      <= 1'b0;
        end else begin
            int_meta <= IntIn;
            ip4      <= int_meta;
        end
    end

    assign intp      = ((st_im4 & ip4) | (st_im7 & ip7)) & ~st_exl & st_ie;
    assign can_take  = ~rst & (state == RUN) & MemValid;
    assign take_int  = can_take & intp;
    assign take_sys  = can_take & ~intp & ExcSyscall;
    assign take_eret = can_take & ~intp & ~ExcSyscall & ExcEret;
    assign taken     = take_int | take_sys | take_eret;
    // the flushed MEM instruction must not commit its MTC0
    assign wr_en     = CP0We & (state == RUN) & ~taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            st_im4   <= 1'b0;
            st_exl   <= 1'b0;
            st_ie    <= 1'b0;
            cause_bd <= 1'b0;
            exc_code <= 5'b0;
            epc      <= 32'b0;
        end else begin
            case (state)
                RUN:     if (taken) state <= DRAIN;
                default: state <= RUN;
            endcase
            if (take_int || take_sys) begin
                epc      <= ExcDelay ? MemPC - 32'd4 : MemPC;
                cause_bd <= ExcDelay;
                exc_code <= take_int ? CODE_INT : CODE_SYS;
                st_exl   <= 1'b1;
            end else if (take_eret) begin
                st_exl <= 1'b0;
            end else if (wr_en) begin
                if (CP0WAddr == ADDR_STATUS) begin
                    st_im4 <= CP0WData[12];
                    st_exl <= CP0WData[1];
                    st_ie  <= CP0WData[0];
                end
                if (CP0WAddr == ADDR_EPC) epc <= CP0WData;
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 32'b0;
            compare <= 32'b0;
            ip7     <= 1'b0;
            st_im7  <= 1'b0;
        end else begin
            if (wr_en && CP0WAddr == ADDR_COUNT) count <= CP0WData;
            else                                 count <= count + 32'd1;
            // a COMPARE write acknowledges the timer interrupt
            if (wr_en && CP0WAddr == ADDR_COMPARE) begin
                compare <= CP0WData;
                ip7     <= 1'b0;
            end else if (count == compare && compare != 32'b0) begin
                ip7 <= 1'b1;
            end
            if (wr_en && CP0WAddr == ADDR_STATUS) st_im7 <= CP0WData[15];
        end
    end
`else
    assign st_im7 = 1'b0;
    assign ip7    = 1'b0;
`endif

    always_comb begin
        CP0RData = 32'b0;
        case (CP0RAddr)
            ADDR_STATUS: CP0RData = {16'b0, st_im7, 2'b0, st_im4, 10'b0, st_exl, st_ie};
            ADDR_CAUSE:  CP0RData = {cause_bd, 15'b0, ip7, 2'b0, ip4, 5'b0, exc_code, 2'b0};
            ADDR_EPC:    CP0RData = epc;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   CP0RData = count;
            ADDR_COMPARE: CP0RData = compare;
`endif
            default:     CP0RData = 32'b0;
        endcase
    end

    always_comb begin
        ExcRedirect = 1'b0;
        ExcPC       = 32'b0;
        PCStall     = 1'b0;
        IFIDStall   = 1'b0;
        IDEXStall   = 1'b0;
        PCFlush     = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        EXMEFlush   = 1'b0;
        MEWBFlush   = 1'b0;
        if (rst || taken) begin
            PCFlush   = 1'b1;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            EXMEFlush = 1'b1;
            MEWBFlush = 1'b1;
            if (taken) begin
                ExcRedirect = 1'b1;
                ExcPC       = take_eret ? epc : EXC_VECTOR;
            end
        end else if (stallreq_from_ex) begin
            PCStall   = 1'b1;
            IFIDStall = 1'b1;
            IDEXStall = 1'b1;
            EXMEFlush = 1'b1;
        end else if (stallreq_from_id) begin
            PCStall   = 1'b1;
            IFIDStall = 1'b1;
            IDEXFlush = 1'b1;
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: reset, SYSCALL/INT/ERET entry, DRAIN behaviour, stalls, timer option.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemValid, ExcSyscall, ExcEret, ExcDelay, IntIn;
    logic [31:0] MemPC;
    logic        stallreq_from_id, stallreq_from_ex;
    logic        CP0We;
    logic [4:0]  CP0WAddr, CP0RAddr;
    logic [31:0] CP0WData, CP0RData;
    logic        ExcRedirect;
    logic [31:0] ExcPC;
    logic        PCStall, IFIDStall, IDEXStall;
    logic        PCFlush, IFIDFlush, IDEXFlush, EXMEFlush, MEWBFlush;

    int n_assert = 0;
    int n_fail   = 0;

    cp0_exc_unit dut (
        .clk(clk), .rst(rst), .MemValid(MemValid), .MemPC(MemPC),
        .ExcSyscall(ExcSyscall), .ExcEret(ExcEret), .ExcDelay(ExcDelay), .IntIn(IntIn),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .CP0We(CP0We), .CP0WAddr(CP0WAddr), .CP0WData(CP0WData),
        .CP0RAddr(CP0RAddr), .CP0RData(CP0RData),
        .ExcRedirect(ExcRedirect), .ExcPC(ExcPC),
        .PCStall(PCStall), .IFIDStall(IFIDStall), .IDEXStall(IDEXStall),
        .PCFlush(PCFlush), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .EXMEFlush(EXMEFlush), .MEWBFlush(MEWBFlush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        CP0RAddr = a;
        #1;
        chk(tag, CP0RData, exp);
    endtask

    // control vector is {redirect, PC/IFID/IDEX stall, PC/IFID/IDEX/EXME/MEWB flush}
    task automatic ctl(input string tag, input logic r, input logic [31:0] pc,
                       input logic [4:0] fl, input logic [2:0] st);
        #1;
        chk({tag, "_ctl"}, {23'b0, ExcRedirect, PCStall, IFIDStall, IDEXStall,
                            PCFlush, IFIDFlush, IDEXFlush, EXMEFlush, MEWBFlush},
            {23'b0, r, st, fl});
        chk({tag, "_pc"}, ExcPC, pc);
    endtask

    task automatic clear();
        MemValid = 1'b0; ExcSyscall = 1'b0; ExcEret = 1'b0; ExcDelay = 1'b0;
        MemPC = 32'b0; stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0;
        CP0We = 1'b0; CP0WAddr = 5'b0; CP0WData = 32'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        CP0We = 1'b1; CP0WAddr = a; CP0WData = d;
    endtask

    initial begin
        rst = 1'b1; IntIn = 1'b0; CP0RAddr = 5'd12;
        clear();
        #2;
        ctl("rst_hold", 1'b0, 32'h0, 5'h1F, 3'b000);
        rd(5'd12, 32'h0, "rst_status");
        step();
        MemValid = 1'b1; ExcSyscall = 1'b1; stallreq_from_ex = 1'b1;
        ctl("rst_sys", 1'b0, 32'h0, 5'h1F, 3'b000);
        clear();
        rst = 1'b0;
        step();
        ctl("idle", 1'b0, 32'h0, 5'h00, 3'b000);
        rd(5'd12, 32'h0, "idle_status");
        rd(5'd13, 32'h0, "idle_cause");
        rd(5'd14, 32'h0, "idle_epc");

        // SYSCALL; its own MTC0 must be dropped
        MemValid = 1'b1; ExcSyscall = 1'b1; MemPC = 32'h0000_1000;
        mtc0(5'd14, 32'hDEAD_BEEF);
        ctl("sys_take", 1'b1, 32'h8000_0180, 5'h1F, 3'b000);
        step(); clear();
        MemValid = 1'b1; ExcEret = 1'b1; mtc0(5'd14, 32'h5555_5555);
        ctl("drain_eret", 1'b0, 32'h0, 5'h00, 3'b000);
        rd(5'd14, 32'h0000_1000, "sys_epc");
        rd(5'd13, 32'h0000_0020, "sys_cause");
        rd(5'd12, 32'h0000_0002, "sys_status");
        step(); clear();
        rd(5'd14, 32'h0000_1000, "drain_we_ignored");

        // ERET
        mtc0(5'd14, 32'h0000_1004);
        rd(5'd14, 32'h0000_1000, "no_writethrough");
        step(); clear();
        rd(5'd14, 32'h0000_1004, "epc_write");
        MemValid = 1'b1; ExcEret = 1'b1;
        ctl("eret_take", 1'b1, 32'h0000_1004, 5'h1F, 3'b000);
        step(); clear();
        rd(5'd12, 32'h0, "eret_status");
        MemValid = 1'b1; ExcSyscall = 1'b1;
        ctl("drain_sys", 1'b0, 32'h0, 5'h00, 3'b000);
        step(); clear();

        // stalls
        stallreq_from_id = 1'b1;
        ctl("stall_id", 1'b0, 32'h0, 5'b00100, 3'b110);
        stallreq_from_ex = 1'b1;
        ctl("stall_both", 1'b0, 32'h0, 5'b00010, 3'b111);
        MemValid = 1'b1; ExcSyscall = 1'b1; MemPC = 32'h0000_3000;
        ctl("sys_over_stall", 1'b1, 32'h8000_0180, 5'h1F, 3'b000);
        step();
        MemValid = 1'b0; ExcSyscall = 1'b0;
        ctl("drain_stall", 1'b0, 32'h0, 5'b00010, 3'b111);
        step(); clear();

        // interrupt in a delay slot, through the synchronizer
        mtc0(5'd12, 32'h0000_1001);
        step(); clear();
        rd(5'd12, 32'h0000_1001, "status_wr");
        IntIn = 1'b1; MemValid = 1'b1; MemPC = 32'h0000_2004; ExcDelay = 1'b1;
        ctl("int_sync0", 1'b0, 32'h0, 5'h00, 3'b000);
        step();
        ctl("int_sync1", 1'b0, 32'h0, 5'h00, 3'b000);
        step();
        ctl("int_take", 1'b1, 32'h8000_0180, 5'h1F, 3'b000);
        step(); clear();
        rd(5'd14, 32'h0000_2000, "int_epc");
        rd(5'd13, 32'h8000_1000, "int_cause");
        rd(5'd12, 32'h0000_1003, "int_status");
        step();
        MemValid = 1'b1;
        ctl("exl_masks", 1'b0, 32'h0, 5'h00, 3'b000);
        clear();
        mtc0(5'd12, 32'h0000_1001);
        step(); clear();
        MemValid = 1'b1; ExcSyscall = 1'b1; MemPC = 32'h0000_2008;
        ctl("int_prio", 1'b1, 32'h8000_0180, 5'h1F, 3'b000);
        step(); clear();
        rd(5'd13, 32'h0000_1000, "prio_cause");
        rd(5'd14, 32'h0000_2008, "prio_epc");
        IntIn = 1'b0;
        step();

`ifdef CP0_TIMER_EN
        mtc0(5'd12, 32'h0000_8001);
        step(); mtc0(5'd11, 32'd5);
        step(); mtc0(5'd9, 32'd0);
        step(); clear();
        rd(5'd9, 32'd0, "count_wr");
        rd(5'd12, 32'h0000_8001, "im7_status");
        for (int i = 0; i < 20; i++) begin
            CP0RAddr = 5'd13;
            #1;
            if (CP0RData[15]) break;
            step();
        end
        chk("timer_ip7", {31'b0, CP0RData[15]}, 32'd1);
        MemValid = 1'b1;
        ctl("timer_take", 1'b1, 32'h8000_0180, 5'h1F, 3'b000);
        step(); clear();
        step();
        mtc0(5'd11, 32'd1000);
        step(); clear();
        rd(5'd13, 32'h0, "cmp_clear");
        rd(5'd11, 32'd1000, "cmp_read");
        mtc0(5'd12, 32'h0);
        step(); clear();
`else
        mtc0(5'd11, 32'd5);
        step(); clear();
        rd(5'd11, 32'h0, "cmp_absent");
        rd(5'd9, 32'h0, "cnt_absent");
        mtc0(5'd12, 32'h0000_8001);
        step(); clear();
        rd(5'd12, 32'h0000_0001, "im7_absent");
`endif

        // async reset in the middle of DRAIN
        MemValid = 1'b1; ExcSyscall = 1'b1; MemPC = 32'h0000_4000;
        step(); clear();
        #1;
        rst = 1'b1;
        MemValid = 1'b1; ExcSyscall = 1'b1;
        ctl("rst_drain", 1'b0, 32'h0, 5'h1F, 3'b000);
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd12, 32'h0, "rst_status2");
        step();
        rst = 1'b0; clear();
        MemValid = 1'b1; ExcSyscall = 1'b1; MemPC = 32'h0; ExcDelay = 1'b1;
        ctl("post_rst_run", 1'b1, 32'h8000_0180, 5'h1F, 3'b000);
        rd(5'd13, 32'h0, "post_rst_cause");
        step(); clear();
        rd(5'd14, 32'hFFFF_FFFC, "epc_wrap");
        rd(5'd13, 32'h8000_0020, "wrap_cause");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Sequential CP0 register bank and exception sequencer for the 5-stage MIPS32 pipeline. Holds STATUS, CAUSE and EPC, and decides whether an interrupt, SYSCALL or ERET commits from the MEM stage. On a commit it drives the redirect PC and the per-stage flushes. When no exception is taken, it converts ID/EX stall requests into per-stage stall/bubble controls.

## Interface
- EXC_VECTOR, 32'h8000_0180, redirect target for interrupt and SYSCALL entry
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemValid  in  1  MEM stage holds a real instruction (not a bubble)
- MemPC  in  32  PC of the MEM-stage instruction
- ExcSyscall  in  1  MEM instruction is SYSCALL
- ExcEret  in  1  MEM instruction is ERET
- ExcDelay  in  1  MEM instruction sits in a branch delay slot
- IntIn  in  1  asynchronous external interrupt level, mapped to IP4
- stallreq_from_id  in  1  ID stage stall request
- stallreq_from_ex  in  1  EX stage stall request
- CP0We  in  1  MTC0 write enable (MEM stage)
- CP0WAddr  in  5  MTC0 register number
- CP0WData  in  32  MTC0 data
- CP0RAddr  in  5  MFC0 register number
- CP0RData  out  32  MFC0 read data, combinational from registered state
- ExcRedirect  out  1  PC must load ExcPC this cycle
- ExcPC  out  32  redirect target
- PCStall, IFIDStall, IDEXStall  out  1 each  hold the stage register
- PCFlush, IFIDFlush, IDEXFlush, EXMEFlush, MEWBFlush  out  1 each  clear the stage register

## Operation
- Registers: STATUS(12), CAUSE(13), EPC(14). Other addresses read as 0.
- STATUS writable bits: [15] IM7, [12] IM4, [1] EXL, [0] IE. All other bits read 0.
- CAUSE is read-only to MTC0:
  - [31] BD
  - [15] IP7 (timer)
  - [12] IP4
  - [6:2] ExcCode: 00000 for Int, 01000 for Sys
- EPC is fully writable.
- IP4 is driven from IntIn through a 2-flop synchronizer and tracks the level; it is not latched.
- Interrupt pending (IntP) = ((STATUS[12] & CAUSE[12]) | (STATUS[15] & CAUSE[15])) & STATUS[1:0]==2'b01.
- Events are evaluated only when state is RUN and MemValid=1. Priority order is IntP, then ExcSyscall, then ExcEret.
- Entry, for IntP or SYSCALL:
  - EPC <= ExcDelay ? MemPC-4 : MemPC
  - CAUSE[31] <= ExcDelay
  - ExcCode <= Int/Sys
  - STATUS[1] <= 1
  - ExcPC = EXC_VECTOR
- ERET:
  - STATUS[1] <= 0
  - ExcPC = current EPC register value (pre-update)
- On any taken event, in the same cycle:
  - ExcRedirect = 1
  - all five flushes = 1
  - all stalls = 0
  - the state moves to DRAIN
- A taken event also discards a same-cycle CP0We, because the MEM instruction is flushed.
- State machine:
  - RUN to DRAIN on a taken event.
  - DRAIN to RUN unconditionally after 1 cycle.
  - In DRAIN no events are taken, CP0We is ignored, and stall outputs follow the normal stall rules.
- Stall rules when no event is taken:
  - stallreq_from_ex: PCStall, IFIDStall and IDEXStall = 1, and EXMEFlush = 1 (bubble).
  - Otherwise stallreq_from_id: PCStall and IFIDStall = 1, and IDEXFlush = 1.
  - With neither request, all stall and flush outputs are 0.
- ExcPC = 0 whenever ExcRedirect = 0.

## Timing
- Event decision, ExcPC, ExcRedirect, flushes and stalls are combinational from the inputs and the registered state, with zero-cycle latency.
- CP0 updates take effect at the rising edge that ends the event cycle. CP0RData shows the new values in the following cycle.
- A CP0We in cycle N is visible on CP0RData in cycle N+1; there is no write-through.
- IntIn latency: CAUSE[12] = 1 after the 2nd rising edge following IntIn's rise. The interrupt is taken in the first later RUN cycle with MemValid=1 and IntP=1.
- Back-to-back events: a second event in the DRAIN cycle is ignored.
- Reset (async, any time, including mid-DRAIN):
  - state = RUN
  - STATUS = CAUSE = EPC = 0
  - synchronizer flops = 0
  - while rst is high: all five flushes = 1, all stalls = 0, ExcRedirect = 0, ExcPC = 0, CP0RData = 0
- Arithmetic: MemPC-4 is a 32-bit modulo subtraction (0 wraps to 32'hFFFF_FFFC).

## Configuration
- CP0_TIMER_EN defined:
  - Adds COUNT(9) and COMPARE(11), both 32 bits, reset value 0.
  - COUNT increments by 1 every cycle (wrapping) unless written that cycle.
  - CAUSE[15] is set when COUNT==COMPARE and COMPARE!=0.
  - CAUSE[15] is cleared by any COMPARE write.
  - Both registers are MTC0 writable and MFC0 readable.
- CP0_TIMER_EN undefined:
  - No COUNT or COMPARE registers exist; addresses 9 and 11 read 0 and writes are ignored.
  - CAUSE[15] is constant 0, and STATUS[15] reads 0.

## Test plan
- Reset: assert rst mid-DRAIN, then release -> all flushes 1 during rst; afterwards STATUS=CAUSE=EPC=0, state RUN, all outputs 0.
- SYSCALL at MemPC=0x0000_1000, ExcDelay=0 -> ExcRedirect=1, ExcPC=0x8000_0180, all flushes 1 that cycle; next cycle EPC=0x1000, ExcCode=01000, EXL=1, BD=0.
- Interrupt in delay slot:
  - Setup: STATUS=0x1001, raise IntIn, MemPC=0x2004, ExcDelay=1.
  - Required: redirect to 0x8000_0180 is taken no earlier than 2 edges after IntIn rises; EPC=0x2000, BD=1, ExcCode=0.
  - Priority: repeat with ExcSyscall=1 in the same cycle; the interrupt wins.
- ERET with EPC=0x1004 -> ExcPC=0x1004, flushes 1; next cycle EXL=0. An ERET or SYSCALL presented in the DRAIN cycle is not taken.
- Stalls:
  - stallreq_from_id only -> PC/IFID stall, IDEXFlush=1.
  - both requests -> PC/IFID/IDEX stall, EXMEFlush=1.
  - SYSCALL with stallreq_from_ex -> stalls 0, all flushes 1.
- CP0_TIMER_EN: write COMPARE=5, COUNT=0 -> CAUSE[15]=1 once COUNT reaches 5; with STATUS=0x8001 the interrupt is taken; a COMPARE write clears CAUSE[15].
